// File: rtl/ram_seq_pkg.sv
// Shared types and sizing for the burst sequencer that fronts a 16-word single-port RAM.
package ram_seq_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int ADDR_W_DFLT = 4;
    localparam int DEPTH       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_seq_rdbuf.sv
// Single-entry read output register: holds one captured RAM word until the consumer takes it.
module ram_seq_rdbuf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              rd_ready_i,
    output logic              space_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // A new word may land when empty, or when the held word leaves on this same edge.
    assign space_o    = !valid_q || rd_ready_i;
    assign rd_valid_o = valid_q;
    assign rd_data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (cap_i) begin
            valid_q <= 1'b1;
            data_q  <= din_i;
        end else if (rd_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_seq.sv
// Burst sequencer: turns one command into 1..16 address-incrementing RAM beats with stream handshakes.
module ram_seq
    import ram_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Dout,
    input  logic [DATA_W-1:0] Din,
    output logic              WE,
    output logic              CS
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_space;
    logic              wr_beat, rd_beat, beat;

    assign addr_d = addr_q + 1'b1;
    assign cnt_d  = cnt_q - 1'b1;

    // WE only exists in WRITE and a capture only in READ, so they can never coincide.
    assign wr_beat = (state_q == WRITE) && wr_valid;
    assign rd_beat = (state_q == READ) && rd_space;
    assign beat    = wr_beat || rd_beat;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign CS        = (state_q == WRITE) || (state_q == READ);
    assign wr_ready  = (state_q == WRITE);
    assign WE        = wr_beat;
    assign Dout      = wr_beat ? wr_data : '0;
    assign Address   = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        cnt_q   <= cmd_len;
                        state_q <= cmd_write ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (beat) begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_d;
                        if (cnt_q == '0) state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    ram_seq_rdbuf #(
        .DATA_W(DATA_W)
    ) u_rdbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_i     (rd_beat),
        .din_i     (Din),
        .rd_ready_i(rd_ready),
        .space_o   (rd_space),
        .rd_valid_o(rd_valid),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_ram_seq.sv
// Bench for ram_seq attached to a behavioural 16x8 RAM, with a read-data scoreboard.
module tb_ram_seq;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b1;
    logic          cmd_ready, wr_ready, rd_valid, busy, done, WE, CS;
    logic [DW-1:0] rd_data, Dout, Din;
    logic [AW-1:0] Address;

    ram_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .Address(Address), .Dout(Dout), .Din(Din), .WE(WE), .CS(CS)
    );

    always #5 clk = ~clk;

    // 16x8 RAM, synchronous write, combinational read
    logic [DW-1:0] mem [16];
    assign Din = mem[Address];
    always @(posedge clk) if (CS && WE) mem[Address] <= Dout;

    logic [DW-1:0] exp_mem [16];
    logic [DW-1:0] rq [$];
    int checks = 0, errors = 0;
    int we_cnt = 0, done_cnt = 0;
    logic          stalled_prev = 1'b0;
    logic [AW-1:0] stall_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (WE) begin
                we_cnt++;
                chk("we_cs_wrready", {30'd0, CS, wr_ready}, 32'd3);
                chk("dout_on_we", Dout, wr_data);
            end else begin
                chk("dout_idle_zero", Dout, 0);
            end
            if (done) done_cnt++;
            if (stalled_prev) chk("addr_hold_stall", Address, stall_addr);
            stalled_prev = CS && !wr_ready && rd_valid && !rd_ready;
            stall_addr   = Address;
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got %0h expected no beat", rd_data);
                end else begin
                    chk("rd_data", rd_data, rq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Returns one cycle after the accepting edge.
    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: got cmd_ready 0 expected 1");
        end
        tick();
        cmd_valid = 1'b0;
        chk("cs_after_accept", {31'd0, CS}, 1);
        chk("addr_after_accept", Address, a);
        chk("cmd_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l,
                            input logic [DW-1:0] base, input logic [DW-1:0] step, input bit gaps);
        int beats = 0, cyc = 0, we0, dn0;
        logic [AW-1:0] ad;
        we0 = we_cnt; dn0 = done_cnt;
        send_cmd(1'b1, a, l);
        while (beats <= int'(l) && cyc < 200) begin
            wr_valid = !(gaps && (cyc % 2 == 1));
            wr_data  = base + DW'(beats) * step;
            if (gaps && cyc == 1) begin
                cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hF; cmd_len = 4'h0;
                chk("cmd_ready_mid_burst", {31'd0, cmd_ready}, 0);
            end
            if (wr_valid && wr_ready) begin
                ad = a + AW'(beats);
                exp_mem[ad] = wr_data;
                beats++;
            end
            tick();
            cmd_valid = 1'b0;
            cyc++;
        end
        wr_valid = 1'b0;
        if (beats <= int'(l)) begin
            checks++; errors++;
            $display("FAIL wr_timeout: got %0d beats expected %0d", beats, int'(l) + 1);
        end
        chk("wr_done_pulse", {31'd0, done}, 1);
        chk("we_cycles", we_cnt - we0, int'(l) + 1);
        tick();
        chk("done_then_idle", {30'd0, done, cmd_ready}, 32'd1);
        chk("wr_done_count", done_cnt - dn0, 1);
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + AW'(i);
            chk("ram_contents", mem[ad], base + DW'(i) * step);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input bit stall);
        int cyc = 0, dn0;
        logic [AW-1:0] ad;
        dn0 = done_cnt;
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + AW'(i);
            rq.push_back(exp_mem[ad]);
        end
        rd_ready = 1'b1;
        send_cmd(1'b0, a, l);
        chk("rd_valid_at_accept1", {31'd0, rd_valid}, 0);
        if (!stall) begin
            for (int i = 0; i <= int'(l); i++) begin
                tick();
                chk("rd_valid_streaming", {31'd0, rd_valid}, 1);
            end
            chk("rd_done_pulse", {31'd0, done}, 1);
            tick();
        end else begin
            while (rq.size() > 0 && cyc < 300) begin
                rd_ready = (cyc % 3 == 0);
                tick();
                cyc++;
            end
            rd_ready = 1'b1;
            tick(); tick();
        end
        chk("rd_all_consumed", rq.size(), 0);
        chk("rd_done_count", done_cnt - dn0, 1);
        chk("rd_valid_drained", {31'd0, rd_valid}, 0);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        logic [DW-1:0] base;
        logic [DW-1:0] step;
        bit            alt;   // write: wr_valid gaps; read: rd_ready 1,0,0 pattern
    } vec_t;

    vec_t vt [9];
    int   dn_r;

    initial begin
        vt[0] = '{1'b1, 4'd3,  4'd3,  8'h11, 8'h11, 1'b0};
        vt[1] = '{1'b0, 4'd3,  4'd3,  8'h00, 8'h00, 1'b0};
        vt[2] = '{1'b1, 4'd14, 4'd3,  8'hA0, 8'h01, 1'b0};
        vt[3] = '{1'b0, 4'd14, 4'd3,  8'h00, 8'h00, 1'b0};
        vt[4] = '{1'b1, 4'd0,  4'd15, 8'h30, 8'h03, 1'b0};
        vt[5] = '{1'b0, 4'd0,  4'd15, 8'h00, 8'h00, 1'b1};
        vt[6] = '{1'b1, 4'd5,  4'd4,  8'hC0, 8'h07, 1'b1};
        vt[7] = '{1'b0, 4'd5,  4'd4,  8'h00, 8'h00, 1'b0};
        vt[8] = '{1'b0, 4'd15, 4'd0,  8'h00, 8'h00, 1'b0};

        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_outs_low", {25'd0, wr_ready, WE, CS, busy, done, rd_valid, 1'b0}, 0);
        chk("rst_addr_dout", {Address, Dout}, 0);
        chk("rst_rd_data", rd_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            if (vt[v].wr) do_write(vt[v].addr, vt[v].len, vt[v].base, vt[v].step, vt[v].alt);
            else          do_read(vt[v].addr, vt[v].len, vt[v].alt);
        end

        // Pending read word survives DONE/IDLE and a following write command.
        dn_r = done_cnt;
        rd_ready = 1'b0;
        rq.push_back(exp_mem[3]);
        send_cmd(1'b0, 4'd3, 4'd0);
        tick(); tick();
        chk("pending_valid_idle", {30'd0, rd_valid, cmd_ready}, 32'd3);
        chk("pending_data_idle", rd_data, exp_mem[3]);
        do_write(4'd9, 4'd0, 8'h99, 8'h00, 1'b0);
        chk("pending_valid_after_wr", {31'd0, rd_valid}, 1);
        chk("pending_data_after_wr", rd_data, exp_mem[3]);
        rd_ready = 1'b1;
        tick();
        chk("pending_consumed", rq.size(), 0);
        chk("pending_rd_valid_clr", {31'd0, rd_valid}, 0);
        chk("pending_done_count", done_cnt - dn_r, 2);

        // Reset after two of four write beats.
        send_cmd(1'b1, 4'd8, 4'd3);
        wr_valid = 1'b1; wr_data = 8'h51; exp_mem[8] = 8'h51;
        tick();
        wr_data = 8'h52; exp_mem[9] = 8'h52;
        tick();
        wr_data = 8'h53;
        chk("pre_reset_we", {31'd0, WE}, 1);
        dn_r = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_cs", {30'd0, WE, CS}, 0);
        chk("rst_mid_ready", {29'd0, cmd_ready, wr_ready, busy}, 32'd4);
        chk("rst_mid_done_addr", {Address, done}, 0);
        wr_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_done", done_cnt - dn_r, 0);
        chk("rst_ram_untouched", mem[10], exp_mem[10]);
        do_read(4'd8, 4'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_seq.md
RAM_SEQ -- requirements
Module: ram_seq

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, data width; ADDR_W, default 4, address width; RAM depth is 2^ADDR_W = 16.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid  in  1  command offered.
REQ-005 SHALL have port: cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clock edge.
REQ-006 SHALL have port: cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have port: cmd_addr  in  ADDR_W  burst start address.
REQ-008 SHALL have port: cmd_len  in  ADDR_W  beats minus one (0..15 -> 1..16 beats).
REQ-009 SHALL have ports: wr_valid  in  1; wr_ready  out  1; wr_data  in  DATA_W  write-beat stream.
REQ-010 SHALL have ports: rd_valid  out  1; rd_ready  in  1; rd_data  out  DATA_W  read-beat stream.
REQ-011 SHALL have ports: busy  out  1  (state != IDLE); done  out  1  one-cycle burst-complete pulse.
REQ-012 SHALL have RAM-side ports: Address  out  ADDR_W; Dout  out  DATA_W (to RAM in); Din  in  DATA_W (from RAM out, combinational read); WE  out  1; CS  out  1.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, READ, DONE.
REQ-014 SHALL drive cmd_ready = 1 only in IDLE; cmd_valid SHALL be ignored in all other states.
REQ-015 On command accept in IDLE: SHALL load Address <= cmd_addr, beat counter <= cmd_len, go to WRITE if cmd_write else READ.
REQ-016 SHALL drive CS = 1 exactly in WRITE and READ, else 0.
REQ-017 In WRITE: wr_ready = 1; WE = wr_valid (combinational); Dout = wr_data when WE, else 0; wr_ready SHALL be 0 in all other states.
REQ-018 A write beat SHALL commit on each edge with wr_valid & wr_ready; wr_valid low SHALL stall with no address/counter change.
REQ-019 In READ, a beat SHALL commit on each edge where (!rd_valid | rd_ready): rd_data <= Din, rd_valid <= 1.
REQ-020 rd_valid SHALL clear on rd_ready when no new beat is captured that edge; rd_data SHALL hold while rd_valid & !rd_ready.
REQ-021 Each committed beat SHALL increment Address modulo 16 (15 -> 0 wrap) and decrement the counter.
REQ-022 The beat committed with counter = 0 SHALL be last: next state DONE.
REQ-023 DONE SHALL last one cycle with done = 1, then IDLE; cmd_ready reasserts the cycle after done.
REQ-024 Latency: accept at edge N -> Address/CS valid during cycle N+1; first read beat rd_valid high at N+2 (with rd_ready held 1); one beat per cycle sustained.
REQ-025 rd_valid/rd_data SHALL persist across DONE/IDLE until consumed; a new command SHALL be accepted regardless of pending rd_valid.
REQ-026 WE SHALL never be asserted outside WRITE; WE and a read capture SHALL never occur on the same edge.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, Address 0, counter 0, rd_valid 0, rd_data 0.
REQ-028 Resulting output values during/after reset: cmd_ready 1, wr_ready 0, WE 0, CS 0, Dout 0, busy 0, done 0.
REQ-029 Reset mid-burst SHALL abort the burst without done pulse; beats already committed remain in RAM.

Structure
REQ-030 Package ram_seq_pkg SHALL hold the state enum, DATA_W/ADDR_W defaults and DEPTH = 16.
REQ-031 The single-entry read output register SHALL be a sub-module ram_seq_rdbuf; the rest stays flat; the 16x8 RAM is not instantiated inside.

Verification (bench connects ram_seq to the team's 16x8 RAM)
REQ-032 Write addr 3, len 3, data 0x11,0x22,0x33,0x44, wr_valid always 1 -> WE high 4 cycles, RAM[3..6] = 0x11..0x44, one done pulse.
REQ-033 Read addr 3, len 3, rd_ready 1 -> rd_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, first at accept+2.
REQ-034 Write addr 14, len 3 (data 0xA0..0xA3), then read addr 14 len 3 -> RAM[14,15,0,1] = 0xA0..0xA3, read returns same order.
REQ-035 Read len 15 with rd_ready toggling 1,0,0,1... -> all 16 words delivered in order, none dropped/duplicated, Address never advances while stalled.
REQ-036 Write burst with wr_valid gaps -> no WE during gaps, correct contents; cmd_valid asserted mid-burst ignored.
REQ-037 Assert rst_n=0 after 2 of 4 write beats -> WE/CS drop immediately, no done, cmd_ready 1; subsequent read of those 2 addresses returns the committed data.
